// File: rtl/sum_acc_axil.sv
// AXI4-Lite slave with NUM_CH accumulator channels (ADD/ACC/CNT/CTRL words per 16-byte slot).
// Latency: AW/W ready one cycle after both valid, B one cycle later; AR ready one cycle after valid, R one cycle later.
// Backpressure: no new write while BVALID is held, no new read while RVALID is held; lone AW or W waits unconsumed.
// Optional build macro SUM_ACC_SAT_EN: ADD saturates ACC at all-ones instead of wrapping.
module sum_acc_axil #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_CH             = 4,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            irq
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int SW  = DW / 8;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [AW:0] LIMIT = (AW+1)'(NUM_CH * 16);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Per-channel state
  logic [DW-1:0]        r_acc  [NUM_CH];
  logic [DW-1:0]        r_last [NUM_CH];
  logic [CNT_WIDTH-1:0] r_cnt  [NUM_CH];
  logic [NUM_CH-1:0]    r_ovf;
  logic [NUM_CH-1:0]    r_en;
  logic [NUM_CH-1:0]    r_ie;

  // Bus-side registers
  logic          r_wr_rdy;
  logic          r_bvalid;
  logic [1:0]    r_bresp;
  logic          r_arready;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_rresp;
  logic          r_irq;

  // Write-side decode
  logic [AW-1:0]  w_aw_word;
  logic [CHW-1:0] w_aw_ch;
  logic [1:0]     w_aw_off;
  logic           w_aw_ok;
  logic           w_wr_fire;
  logic [DW-1:0]  w_mask;
  logic [DW-1:0]  w_operand;
  logic [DW:0]    w_sum;

  // Read-side decode
  logic [AW-1:0]  w_ar_word;
  logic [CHW-1:0] w_ar_ch;
  logic [1:0]     w_ar_off;
  logic           w_ar_ok;
  logic           w_rd_fire;
  logic [DW-1:0]  w_cnt_ext;
  logic [DW-1:0]  w_rd_data;

  logic           w_unused;

  assign w_aw_word = S_AXI_AWADDR >> 4;
  assign w_aw_ch   = w_aw_word[CHW-1:0];
  assign w_aw_off  = S_AXI_AWADDR[3:2];
  assign w_aw_ok   = ({1'b0, S_AXI_AWADDR} < LIMIT);
  // The master holds AW/W valid through the ready cycle, so the commit is the ready cycle itself.
  assign w_wr_fire = r_wr_rdy & S_AXI_AWVALID & S_AXI_WVALID;

  assign w_ar_word = S_AXI_ARADDR >> 4;
  assign w_ar_ch   = w_ar_word[CHW-1:0];
  assign w_ar_off  = S_AXI_ARADDR[3:2];
  assign w_ar_ok   = ({1'b0, S_AXI_ARADDR} < LIMIT);
  assign w_rd_fire = r_arready & S_AXI_ARVALID;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_aw_word, w_ar_word,
                      S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Expand byte strobes into a bit mask; un-strobed bytes of the operand become zero
  always_comb begin
    w_mask = '0;
    for (int b = 0; b < SW; b++) begin
      w_mask[b*8 +: 8] = {8{S_AXI_WSTRB[b]}};
    end
  end

  assign w_operand = S_AXI_WDATA & w_mask;
  assign w_sum     = {1'b0, r_acc[w_aw_ch]} + {1'b0, w_operand};

  // Read mux over pre-write state; out-of-range reads return zero
  always_comb begin
    w_cnt_ext = '0;
    w_cnt_ext[CNT_WIDTH-1:0] = r_cnt[w_ar_ch];
    w_rd_data = '0;
    if (w_ar_ok) begin
      case (w_ar_off)
        2'd0: w_rd_data = r_last[w_ar_ch];
        2'd1: w_rd_data = r_acc[w_ar_ch];
        2'd2: w_rd_data = w_cnt_ext;
        default: w_rd_data[2:0] = {r_ie[w_ar_ch], r_en[w_ar_ch], r_ovf[w_ar_ch]};
      endcase
    end
  end

  // Write handshake: one-cycle AW/W ready pulse, then B held until BREADY
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_wr_rdy <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else begin
      r_wr_rdy <= S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid && !r_wr_rdy;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read handshake: one-cycle AR ready pulse capturing data, then R held until RREADY
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_arready <= S_AXI_ARVALID && !r_rvalid && !r_arready;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Channel register updates on an in-range write commit
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_acc[c]  <= '0;
        r_last[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_ovf <= '0;
      r_en  <= '1;
      r_ie  <= '0;
    end else if (w_wr_fire && w_aw_ok) begin
      case (w_aw_off)
        2'd0: begin
          r_last[w_aw_ch] <= w_operand;
          if (r_en[w_aw_ch]) begin
`ifdef SUM_ACC_SAT_EN
            r_acc[w_aw_ch] <= w_sum[DW] ? '1 : w_sum[DW-1:0];
`else
            r_acc[w_aw_ch] <= w_sum[DW-1:0];
`endif
            r_cnt[w_aw_ch] <= r_cnt[w_aw_ch] + CNT_WIDTH'(1);
            if (w_sum[DW]) begin
              r_ovf[w_aw_ch] <= 1'b1;
            end
          end
        end
        2'd1: begin
          // Direct load: byte-merged, never saturates or flags overflow
          r_acc[w_aw_ch] <= (r_acc[w_aw_ch] & ~w_mask) | (S_AXI_WDATA & w_mask);
        end
        2'd3: begin
          if (S_AXI_WSTRB[0]) begin
            r_en[w_aw_ch] <= S_AXI_WDATA[1];
            r_ie[w_aw_ch] <= S_AXI_WDATA[2];
            if (S_AXI_WDATA[0]) begin
              r_acc[w_aw_ch] <= '0;
              r_cnt[w_aw_ch] <= '0;
              r_ovf[w_aw_ch] <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Interrupt follows registered OVF & IE one cycle later
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_ovf & r_ie);
    end
  end

  assign S_AXI_AWREADY = r_wr_rdy;
  assign S_AXI_WREADY  = r_wr_rdy;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign irq           = r_irq;

endmodule

// File: tb/tb_sum_acc_axil.sv
// Directed self-checking bench for sum_acc_axil (default parameters, 32-bit bus, 4 channels).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// Each scenario task performs its own comparisons; a single summary line ends the run.
module tb_sum_acc_axil;

  logic        clk;
  logic        areset;
  logic [7:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        irq;

  int errors = 0;
  int checks = 0;
  logic irq_at_commit;
  logic irq_after_b;

  sum_acc_axil dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (areset),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(awready && wready) && n < 50);
    checks++;
    if (!(awready && wready)) begin
      errors++;
      $display("FAIL write_accept addr=%h: ready=%b required 1 within 50 cycles", addr, awready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    irq_at_commit = irq;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    irq_after_b = irq;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!arready && n < 50);
    checks++;
    if (!arready) begin
      errors++;
      $display("FAIL read_accept addr=%h: arready=%b required 1 within 50 cycles", addr, arready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    do_reset();
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, irq} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl_outs: got %b required 000000", {awready, wready, bvalid, arready, rvalid, irq});
    end
    checks++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      errors++;
      $display("FAIL reset_data_outs: got %h required 0", {bresp, rresp, rdata});
    end
    axi_read(8'h0C, d, r);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL reset_ctrl0: got %h required 00000002", d); end
  endtask

  task automatic test_accumulate();
    logic [31:0] d; logic [1:0] r; logic [1:0] wr;
    for (int i = 1; i <= 4; i++) begin
      axi_write(8'h00, 32'(i), 4'hF, wr);
      checks++;
      if (wr !== 2'b00) begin errors++; $display("FAIL acc_bresp%0d: got %b required 00", i, wr); end
    end
    axi_read(8'h04, d, r);
    checks++;
    if (d !== 32'h0000000A) begin errors++; $display("FAIL acc0: got %h required 0000000a", d); end
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL acc0_rresp: got %b required 00", r); end
    axi_read(8'h08, d, r);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL cnt0: got %h required 00000004", d); end
    axi_read(8'h00, d, r);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL last0: got %h required 00000004", d); end
    for (int c = 1; c < 4; c++) begin
      axi_read(8'(c * 16 + 4), d, r);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL acc%0d_idle: got %h required 0", c, d); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic [1:0] r; logic [1:0] wr;
    logic [31:0] exp1, exp2;
`ifdef SUM_ACC_SAT_EN
    exp1 = 32'hFFFFFFFF; exp2 = 32'hFFFFFFFF;
`else
    exp1 = 32'h00000010; exp2 = 32'h00000011;
`endif
    axi_write(8'h24, 32'hFFFFFFF0, 4'hF, wr);
    axi_write(8'h2C, 32'h6, 4'hF, wr);
    axi_write(8'h20, 32'h20, 4'hF, wr);
    checks++;
    if (irq_at_commit !== 1'b0) begin errors++; $display("FAIL irq_same_cycle: got %b required 0", irq_at_commit); end
    checks++;
    if (irq_after_b !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b required 1", irq_after_b); end
    axi_read(8'h24, d, r);
    checks++;
    if (d !== exp1) begin errors++; $display("FAIL ovf_acc2: got %h required %h", d, exp1); end
    axi_read(8'h2C, d, r);
    checks++;
    if (d !== 32'h7) begin errors++; $display("FAIL ovf_ctrl2: got %h required 00000007", d); end
    axi_write(8'h20, 32'h1, 4'hF, wr);
    axi_read(8'h24, d, r);
    checks++;
    if (d !== exp2) begin errors++; $display("FAIL ovf_acc2_next: got %h required %h", d, exp2); end
    axi_read(8'h28, d, r);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL ovf_cnt2: got %h required 00000002", d); end
    axi_write(8'h2C, 32'h7, 4'hF, wr);
    axi_read(8'h24, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL clr_acc2: got %h required 0", d); end
    axi_read(8'h28, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL clr_cnt2: got %h required 0", d); end
    axi_read(8'h2C, d, r);
    checks++;
    if (d !== 32'h6) begin errors++; $display("FAIL clr_ctrl2: got %h required 00000006", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL clr_irq: got %b required 0", irq); end
  endtask

  task automatic test_strobe_enable();
    logic [31:0] d; logic [1:0] r; logic [1:0] wr;
    axi_write(8'h10, 32'h11223344, 4'b0101, wr);
    axi_read(8'h14, d, r);
    checks++;
    if (d !== 32'h00220044) begin errors++; $display("FAIL strb_acc1: got %h required 00220044", d); end
    axi_write(8'h1C, 32'h0, 4'b0001, wr);
    axi_write(8'h10, 32'h5, 4'hF, wr);
    axi_read(8'h14, d, r);
    checks++;
    if (d !== 32'h00220044) begin errors++; $display("FAIL dis_acc1: got %h required 00220044", d); end
    axi_read(8'h10, d, r);
    checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL dis_last1: got %h required 00000005", d); end
    axi_read(8'h18, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL dis_cnt1: got %h required 00000001", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r;
    int early, accepts, bcyc, bad_resp, late;
    early = 0; accepts = 0; bcyc = 0; bad_resp = 0; late = 0;
    awaddr = 8'h30; wdata = 32'h7; wstrb = 4'hF;
    awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (awready || wready) early++;
    end
    wvalid = 1'b1;
    for (int i = 0; i < 20 && bcyc < 3; i++) begin
      @(posedge clk); #1;
      if (awready && wready) accepts++;
      if (bvalid) begin
        bcyc++;
        if (bresp !== 2'b00) bad_resp++;
      end
    end
    bready = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL bp_bvalid_drop: got %b required 0", bvalid); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (awready) late++;
    end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL bp_lone_aw: got %0d accepts required 0", early); end
    checks++;
    if (accepts !== 1) begin errors++; $display("FAIL bp_accepts: got %0d required 1", accepts); end
    checks++;
    if (bcyc !== 3 || bad_resp !== 0) begin
      errors++; $display("FAIL bp_bhold: got %0d cycles/%0d bad required 3/0", bcyc, bad_resp);
    end
    checks++;
    if (late !== 0) begin errors++; $display("FAIL bp_late_accept: got %0d required 0", late); end
    axi_read(8'h38, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL bp_cnt3: got %h required 00000001", d); end
    axi_read(8'h34, d, r);
    checks++;
    if (d !== 32'h7) begin errors++; $display("FAIL bp_acc3: got %h required 00000007", d); end
  endtask

  task automatic test_slverr();
    logic [31:0] d; logic [1:0] r; logic [1:0] wr;
    axi_read(8'h40, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL oor_read: got %h/%b required 0/10", d, r); end
    axi_write(8'h44, 32'h1234, 4'hF, wr);
    checks++;
    if (wr !== 2'b10) begin errors++; $display("FAIL oor_bresp: got %b required 10", wr); end
    axi_read(8'h04, d, r);
    checks++;
    if (d !== 32'h0000000A) begin errors++; $display("FAIL oor_acc0: got %h required 0000000a", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r;
    int n;
    awaddr = 8'h04; wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!awready && n < 50);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL mid_bvalid_pre: got %b required 1", bvalid); end
    areset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bvalid, awready, rvalid, irq} !== 4'b0) begin
      errors++; $display("FAIL mid_reset_outs: got %b required 0000", {bvalid, awready, rvalid, irq});
    end
    areset = 1'b0;
    @(posedge clk); #1;
    axi_read(8'h04, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mid_acc0: got %h required 0", d); end
    axi_read(8'h0C, d, r);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL mid_ctrl0: got %h required 00000002", d); end
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_accumulate();
    test_overflow();
    test_strobe_enable();
    test_back_to_back();
    test_slverr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
